// File: rtl/wb_register_file.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : wb_register_file                                           |
// | Description : General-purpose register bank fed by write-back. Two       |
// |               combinational read ports with same-cycle write bypass,     |
// |               register 0 hard-wired to zero, and a halt-triggered        |
// |               valid/ready dump of every register to the debug unit.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module wb_register_file #(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5,
    parameter int N_REGS  = 32
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_reg_write,
    input  logic [NB_REG-1:0]  i_selected_reg,
    input  logic [NB_DATA-1:0] i_selected_data,
    input  logic               i_halt,
    input  logic [NB_REG-1:0]  i_read_reg_a,
    input  logic [NB_REG-1:0]  i_read_reg_b,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic               o_halted,
    output logic               o_dump_valid,
    input  logic               i_dump_ready,
    output logic [NB_REG-1:0]  o_dump_addr,
    output logic [NB_DATA-1:0] o_dump_data,
    output logic               o_dump_last
);

    // Controller states: normal operation, streaming the dump, dump finished.
    localparam logic [1:0] c_st_run  = 2'd0;
    localparam logic [1:0] c_st_dump = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    localparam logic [NB_REG-1:0] c_last_idx = NB_REG'(N_REGS - 1);
    localparam logic [NB_REG-1:0] c_one      = NB_REG'(1);

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [NB_REG-1:0]  r_count;
    logic [NB_DATA-1:0] r_regs [N_REGS];

    logic w_write_en;
    logic w_last;
    logic w_transfer;

    // A write only lands while running and never targets register 0.
    assign w_write_en = i_reg_write && (i_selected_reg != '0) && (r_state == c_st_run);

    assign w_last     = (r_state == c_st_dump) && (r_count == c_last_idx);
    assign w_transfer = (r_state == c_st_dump) && i_dump_ready;

    // Read port: zero register, then bypass of the in-flight write, then array.
    function automatic logic [NB_DATA-1:0] read_port(
        input logic [NB_REG-1:0]  addr,
        input logic               wr_en,
        input logic [NB_REG-1:0]  wr_addr,
        input logic [NB_DATA-1:0] wr_data,
        input logic [NB_DATA-1:0] arr_data
    );
        if (addr == '0) begin
            return '0;
        end else if (wr_en && (wr_addr == addr)) begin
            return wr_data;
        end else begin
            return arr_data;
        end
    endfunction

    assign o_data_a = read_port(i_read_reg_a, w_write_en, i_selected_reg,
                                i_selected_data, r_regs[i_read_reg_a]);
    assign o_data_b = read_port(i_read_reg_b, w_write_en, i_selected_reg,
                                i_selected_data, r_regs[i_read_reg_b]);

    // Dump port mirrors the counter; data stays tied to the counter so it
    // holds steady for as long as the debug unit withholds ready.
    assign o_halted     = (r_state == c_st_dump) || (r_state == c_st_done);
    assign o_dump_valid = (r_state == c_st_dump);
    assign o_dump_addr  = r_count;
    assign o_dump_data  = r_regs[r_count];
    assign o_dump_last  = w_last;

    // Next-state decode: halt starts the dump, final accepted word ends it.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_run: begin
                if (i_halt) begin
                    w_next_state = c_st_dump;
                end
            end
            c_st_dump: begin
                if (w_transfer && w_last) begin
                    w_next_state = c_st_done;
                end
            end
            c_st_done: begin
                w_next_state = c_st_done;
            end
            default: begin
                w_next_state = c_st_run;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= c_st_run;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Dump counter: cleared on halt entry, advances per accepted word, never wraps.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_count <= '0;
        end else if ((r_state == c_st_run) && i_halt) begin
            r_count <= '0;
        end else if (w_transfer && !w_last) begin
            r_count <= r_count + c_one;
        end
    end

    // Register array: cleared on reset, written by qualifying write-back writes.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int i = 0; i < N_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_write_en) begin
            r_regs[i_selected_reg] <= i_selected_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_register_file.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_wb_register_file                                        |
// | Description : Self-checking bench for wb_register_file: behavioural      |
// |               model compared every cycle plus directed literal checks.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_wb_register_file;

    localparam int NB_DATA = 32;
    localparam int NB_REG  = 5;
    localparam int N_REGS  = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic               reg_write;
    logic [NB_REG-1:0]  sel_reg;
    logic [NB_DATA-1:0] sel_data;
    logic               halt;
    logic [NB_REG-1:0]  rd_a;
    logic [NB_REG-1:0]  rd_b;
    logic [NB_DATA-1:0] data_a;
    logic [NB_DATA-1:0] data_b;
    logic               halted;
    logic               dump_valid;
    logic               dump_ready;
    logic [NB_REG-1:0]  dump_addr;
    logic [NB_DATA-1:0] dump_data;
    logic               dump_last;

    wb_register_file #(
        .NB_DATA (NB_DATA),
        .NB_REG  (NB_REG),
        .N_REGS  (N_REGS)
    ) dut (
        .i_clock         (clk),
        .i_reset         (rst),
        .i_reg_write     (reg_write),
        .i_selected_reg  (sel_reg),
        .i_selected_data (sel_data),
        .i_halt          (halt),
        .i_read_reg_a    (rd_a),
        .i_read_reg_b    (rd_b),
        .o_data_a        (data_a),
        .o_data_b        (data_b),
        .o_halted        (halted),
        .o_dump_valid    (dump_valid),
        .i_dump_ready    (dump_ready),
        .o_dump_addr     (dump_addr),
        .o_dump_data     (dump_data),
        .o_dump_last     (dump_last)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, want, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_regs [N_REGS];
    bit          m_halted = 1'b0;
    bit          m_done   = 1'b0;
    int          m_idx    = 0;
    bit          chk_en   = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_addr;
    logic [31:0] prev_data;

    initial begin
        for (int i = 0; i < N_REGS; i++) m_regs[i] = 32'h0;
    end

    function automatic bit model_wr_ok();
        return reg_write && (sel_reg != 0) && !m_halted;
    endfunction

    function automatic logic [31:0] model_read(input logic [NB_REG-1:0] a);
        if (a == 0) return 32'h0;
        if (model_wr_ok() && (sel_reg == a)) return sel_data;
        return m_regs[a];
    endfunction

    // Compare DUT against the model mid-cycle, then advance the model to
    // what the coming rising edge must produce.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp data_a", data_a, model_read(rd_a));
            check("cmp data_b", data_b, model_read(rd_b));
            check("cmp halted", {31'b0, halted}, {31'b0, m_halted});
            check("cmp valid", {31'b0, dump_valid}, {31'b0, (m_halted && !m_done)});
            if (m_halted && !m_done) begin
                check("cmp dump_addr", {27'b0, dump_addr}, m_idx);
                check("cmp dump_data", dump_data, m_regs[m_idx]);
                check("cmp dump_last", {31'b0, dump_last}, {31'b0, (m_idx == N_REGS - 1)});
            end else begin
                check("cmp dump_last idle", {31'b0, dump_last}, 32'h0);
            end
            if (prev_stall && dump_valid) begin
                check("stall addr stable", {27'b0, dump_addr}, prev_addr);
                check("stall data stable", dump_data, prev_data);
            end
            prev_stall = dump_valid && !dump_ready;
            prev_addr  = {27'b0, dump_addr};
            prev_data  = dump_data;

            if (rst) begin
                for (int i = 0; i < N_REGS; i++) m_regs[i] = 32'h0;
                m_halted   = 1'b0;
                m_done     = 1'b0;
                m_idx      = 0;
                prev_stall = 1'b0;
            end else begin
                if (model_wr_ok()) m_regs[sel_reg] = sel_data;
                if (!m_halted) begin
                    if (halt) begin
                        m_halted = 1'b1;
                        m_idx    = 0;
                    end
                end else if (!m_done && dump_ready) begin
                    if (m_idx == N_REGS - 1) m_done = 1'b1;
                    else m_idx = m_idx + 1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic preload();
        for (int i = 1; i < N_REGS; i++) begin
            reg_write = 1'b1;
            sel_reg   = NB_REG'(i);
            sel_data  = i * 32'h11;
            cyc();
        end
        reg_write = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] preload_val(input int k);
        return (k == 0) ? 32'h0 : k * 32'h11;
    endfunction

    initial begin
        int          nxt;
        int          guard;
        logic [31:0] want;
        bit          pat [6];

        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0;
        pat[3] = 1'b1; pat[4] = 1'b0; pat[5] = 1'b1;

        rst = 1'b1; reg_write = 1'b0; sel_reg = '0; sel_data = '0;
        halt = 1'b0; rd_a = '0; rd_b = '0; dump_ready = 1'b0;
        @(posedge clk);
        chk_en = 1'b1;
        #1;
        cyc();
        rst = 1'b0;

        // Reset state: all registers read zero, no dump activity.
        @(negedge clk);
        check("rst halted", {31'b0, halted}, 32'h0);
        check("rst valid", {31'b0, dump_valid}, 32'h0);
        check("rst dump_addr", {27'b0, dump_addr}, 32'h0);
        check("rst dump_data", dump_data, 32'h0);
        for (int i = 0; i < N_REGS; i++) begin
            rd_a = NB_REG'(i);
            rd_b = NB_REG'(N_REGS - 1 - i);
            @(negedge clk);
            check("rst rd a", data_a, 32'h0);
            check("rst rd b", data_b, 32'h0);
        end
        cyc();

        // Write r5, read back next cycle.
        reg_write = 1'b1; sel_reg = 5'd5; sel_data = 32'hDEADBEEF;
        cyc();
        reg_write = 1'b0; rd_a = 5'd5;
        @(negedge clk);
        check("r5 readback", data_a, 32'hDEADBEEF);
        cyc();

        // Write to r0 is dropped.
        reg_write = 1'b1; sel_reg = 5'd0; sel_data = 32'h1234; rd_a = 5'd0;
        cyc();
        reg_write = 1'b0;
        @(negedge clk);
        check("r0 stays zero", data_a, 32'h0);
        cyc();

        // Same-cycle bypass on both ports, then on r0.
        reg_write = 1'b1; sel_reg = 5'd7; sel_data = 32'hA5A5A5A5;
        rd_a = 5'd7; rd_b = 5'd7;
        @(negedge clk);
        check("bypass a r7", data_a, 32'hA5A5A5A5);
        check("bypass b r7", data_b, 32'hA5A5A5A5);
        cyc();
        sel_reg = 5'd0; rd_a = 5'd0; rd_b = 5'd0;
        @(negedge clk);
        check("bypass a r0", data_a, 32'h0);
        check("bypass b r0", data_b, 32'h0);
        cyc();
        reg_write = 1'b0;

        // Preload, halt together with a write of r3, full-speed dump.
        preload();
        reg_write = 1'b1; sel_reg = 5'd3; sel_data = 32'hCAFE; halt = 1'b1;
        @(negedge clk);
        check("pre-halt halted", {31'b0, halted}, 32'h0);
        cyc();
        reg_write = 1'b0; halt = 1'b0; dump_ready = 1'b1;
        for (int k = 0; k < N_REGS; k++) begin
            @(negedge clk);
            want = (k == 3) ? 32'hCAFE : preload_val(k);
            check("dump1 valid", {31'b0, dump_valid}, 32'h1);
            check("dump1 addr", {27'b0, dump_addr}, k);
            check("dump1 data", dump_data, want);
            check("dump1 last", {31'b0, dump_last}, {31'b0, (k == 31)});
            cyc();
        end
        @(negedge clk);
        check("done valid", {31'b0, dump_valid}, 32'h0);
        check("done halted", {31'b0, halted}, 32'h1);
        dump_ready = 1'b0;
        cyc();

        // Backpressured dump with ready pattern 1,0,0,1,0,1...
        do_reset();
        preload();
        halt = 1'b1;
        cyc();
        halt = 1'b0;
        nxt = 0;
        guard = 0;
        while (nxt < N_REGS && guard < 300) begin
            dump_ready = pat[guard % 6];
            @(negedge clk);
            if (dump_valid && dump_ready) begin
                check("bp addr", {27'b0, dump_addr}, nxt);
                check("bp data", dump_data, preload_val(nxt));
                nxt++;
            end
            guard++;
            cyc();
        end
        check("bp word count", nxt, N_REGS);
        dump_ready = 1'b0;
        @(negedge clk);
        check("bp done valid", {31'b0, dump_valid}, 32'h0);

        // Writes in DONE are ignored.
        reg_write = 1'b1; sel_reg = 5'd9; sel_data = 32'hFFFF; rd_a = 5'd9;
        cyc();
        reg_write = 1'b0;
        @(negedge clk);
        check("done write ignored", data_a, 32'h99);
        halt = 1'b1;
        cyc();
        halt = 1'b0;
        @(negedge clk);
        check("done halt no effect", {31'b0, dump_valid}, 32'h0);

        // Reset in the middle of a dump at word 10.
        do_reset();
        preload();
        halt = 1'b1;
        cyc();
        halt = 1'b0; dump_ready = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!(dump_valid && dump_addr == 5'd9) && guard < 100) begin
            cyc();
            @(negedge clk);
            guard++;
        end
        check("reach word 9", {27'b0, dump_addr}, 32'd9);
        cyc();
        rst = 1'b1; dump_ready = 1'b0;
        @(negedge clk);
        check("word 10 shown", {27'b0, dump_addr}, 32'd10);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("mid rst valid", {31'b0, dump_valid}, 32'h0);
        check("mid rst halted", {31'b0, halted}, 32'h0);
        for (int i = 0; i < N_REGS; i++) begin
            rd_a = NB_REG'(i);
            rd_b = NB_REG'(i);
            @(negedge clk);
            check("mid rst rd", data_a, 32'h0);
        end
        cyc();
        halt = 1'b1;
        cyc();
        halt = 1'b0;
        @(negedge clk);
        check("restart valid", {31'b0, dump_valid}, 32'h1);
        check("restart addr", {27'b0, dump_addr}, 32'h0);
        cyc();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_register_file.md
# wb_register_file

General-purpose register bank at the far end of the write-back stage: accepts the write port driven by write-back (`reg_write`, selected register, selected data, halt), serves the two decode-stage read ports with same-cycle write bypass, and holds register 0 at zero. When write-back signals halt, the block freezes and streams all registers out over a valid/ready dump port to the debug unit.

## Interface
- `NB_DATA`, 32, register width
- `NB_REG`, 5, register address width
- `N_REGS`, 32, number of registers, equal to 2^`NB_REG`

Ports:
- `i_clock`  in  1  system clock, all state on rising edge
- `i_reset`  in  1  synchronous, active-high reset
- `i_reg_write`  in  1  write-back write enable
- `i_selected_reg`  in  `NB_REG`  write address
- `i_selected_data`  in  `NB_DATA`  write data
- `i_halt`  in  1  HALT has reached write-back
- `i_read_reg_a`  in  `NB_REG`  read address A (rs)
- `i_read_reg_b`  in  `NB_REG`  read address B (rt)
- `o_data_a`  out  `NB_DATA`  read data A, combinational
- `o_data_b`  out  `NB_DATA`  read data B, combinational
- `o_halted`  out  1  pipeline halted; register contents frozen
- `o_dump_valid`  out  1  dump word valid
- `i_dump_ready`  in  1  debug unit accepts dump word
- `o_dump_addr`  out  `NB_REG`  register index of the current dump word
- `o_dump_data`  out  `NB_DATA`  register contents of the current dump word
- `o_dump_last`  out  1  current dump word is register `N_REGS`-1

## Operation
- FSM states: RUN, DUMP, DONE. Reset puts the FSM in RUN.
- **Writes.** Register `i_selected_reg` gets `i_selected_data` at the clock edge when all of the following hold:
  - `i_reg_write`=1
  - `i_selected_reg`≠0
  - state is RUN
- Writes to register 0 are dropped. Writes in DUMP or DONE are ignored.
- **Reads.** Each read port returns:
  - 0 if its address is 0
  - else `i_selected_data` if a write to the same address is qualifying this cycle (bypass)
  - else the array contents
- Reads are valid in every state.
- **RUN → DUMP** when `i_halt`=1. A qualifying write in that same cycle still commits. The dump counter is cleared to 0.
- **DUMP behaviour.**
  - `o_dump_valid`=1, `o_dump_addr`=counter, `o_dump_data`=reg[counter].
  - `o_dump_last`=1 when counter=`N_REGS`-1.
  - A transfer happens on a cycle with valid=1 and ready=1; the counter then increments.
  - When the transfer occurs with last=1, go to DONE.
  - While valid=1 and ready=0, addr, data and last stay constant.
- **DONE.** valid=0. The block stays here until reset. `i_halt` has no further effect.
- `o_halted`=1 in DUMP and DONE.
- **Reset** (including mid-dump):
  - all registers cleared to 0; counter cleared to 0
  - `o_halted`, `o_dump_valid`, `o_dump_last` = 0; `o_dump_addr`=0
  - `o_dump_data`=0, which is reg[0]
  - a dump in progress is aborted with no further words

## Timing
- Write latency: 1 edge. Bypass makes the written value visible on the read ports in the same cycle it is presented.
- Halt at edge N (i_halt=1 in cycle N-1) → `o_halted` and `o_dump_valid` high from cycle N.
- With ready held at 1, the dump takes exactly `N_REGS` cycles: one word per cycle, addr 0..31. DONE is entered at the edge after word 31 transfers.
- `o_dump_valid` never deasserts before its transfer completes. ready may arrive before, with or after valid; only the cycle where both are 1 counts.
- The counter never wraps. No transfer occurs past index `N_REGS`-1.
- `i_halt` and `i_reg_write` in the same cycle: the write commits, then the FSM moves to DUMP. The dump shows the new value.

## Test plan
- **Reset.** Reset for 2 cycles, then read all addresses → every `o_data_a`/`o_data_b`=0, `o_halted`=0, `o_dump_valid`=0.
- **Write/read and r0.**
  - Write r5=0xDEADBEEF, then read A=5 → 0xDEADBEEF next cycle.
  - Write r0=0x1234 → read r0 = 0.
- **Bypass.** Same cycle: write r7=0xA5A5A5A5, read A=7, read B=7 → both ports show 0xA5A5A5A5 that cycle. Repeat with r0 → 0.
- **Halt + write + dump, ready=1.**
  - Preload r1..r31 = index×0x11.
  - Halt in the same cycle as writing r3=0xCAFE.
  - Required response: 32 consecutive words, addr 0..31, r3=0xCAFE, last only on addr 31; then valid=0 and `o_halted`=1.
- **Backpressure.**
  - During a dump, drive ready with the pattern 1,0,0,1,0,1… → addr/data stable during every ready=0 cycle, no word skipped or duplicated.
  - During DONE, drive write r9=0xFFFF → r9 is unchanged.
- **Reset mid-dump.** Reset at word 10 → the next cycle shows valid=0 and `o_halted`=0, all regs read 0, and a new halt restarts the dump at addr 0.
